// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM encodings and sizing helper for bit-serial arithmetic cells
package serial_arith_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bin cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             bor, d, bnext, last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_next;
  full_subtractor u_fs (.x(a_sr[0]), .y(b_sr[0]), .bin(bor), .d(d), .bout(bnext));
  // res_sr keeps only the upper WIDTH-1 partial bits; the full word is assembled on the last edge
  assign res_next = {d, res_sr};
  assign last     = cnt == CW'(WIDTH - 1);
  assign busy     = state != ST_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          bor   <= 1'b0;
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          bor    <= bnext;
          cnt    <= last ? '0 : cnt + 1'b1;
          if (last) begin
            diff   <= res_next;
            borrow <= bnext;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
